// File: rtl/axis_fifo_master_if.sv
// ---------------------------------------------------------------------------
// axis_fifo_master_if
//   AXI4-Stream bus bundle for the read-side stage of the async FIFO.
//   Handshake: a beat transfers on a rising clock edge where tvalid and
//   tready are both high. Once tvalid is raised, tdata/tlast/tvalid stay
//   stable until that transfer happens. tready may change freely.
//   Signals:
//     tdata   TDATA_W  stream data     (master -> slave)
//     tvalid  1        beat valid      (master -> slave)
//     tlast   1        last beat       (master -> slave)
//     tready  1        slave can take  (slave  -> master)
// ---------------------------------------------------------------------------
interface axis_fifo_master_if #(
   parameter int TDATA_W = 16
);
   logic [TDATA_W-1:0] tdata;
   logic               tvalid;
   logic               tlast;
   logic               tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_master.sv
// ---------------------------------------------------------------------------
// axis_fifo_master
//   AXI4-Stream master stage on the read side of the async FIFO. Pops
//   first-word-fall-through words and presents them zero-extended on a
//   registered AXIS port, TLAST every PKT_LEN beats, one beat per clock
//   while tready is high. Start/stop is packet aligned.
//   Handshake: a beat transfers on a rising edge where tvalid & tready;
//   while tvalid & !tready the output register holds and nothing is popped.
// Ports:
//   m_axis_aclk     in   clock (FIFO read clock domain)
//   m_axis_aresetn  in   async active-low reset
//   enable          in   stream packets while high
//   stat_clr        in   1-cycle pulse, clears pkt_count and underrun
//   fifo_rd_data    in   FIFO head word, valid while !fifo_empty
//   fifo_empty      in   FIFO empty flag
//   fifo_rd_en      out  pop strobe (combinational)
//   m_axis          if   AXIS master bus (tdata/tvalid/tlast/tready)
//   busy            out  FSM not idle or a beat still pending
//   pkt_count       out  TLAST handshakes since reset/clear, wraps
//   underrun        out  sticky: FIFO ran dry in the middle of a packet
//   dbg_state       out  FSM state (0 IDLE, 1 RUN, 2 DRAIN)
// ---------------------------------------------------------------------------
module axis_fifo_master #(
   parameter int DATA_W  = 14,
   parameter int TDATA_W = 16,
   parameter int PKT_LEN = 16,
   parameter int CNT_W   = 16
) (
   input  logic                  m_axis_aclk,
   input  logic                  m_axis_aresetn,
   input  logic                  enable,
   input  logic                  stat_clr,
   input  logic [DATA_W-1:0]     fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   axis_fifo_master_if.master    m_axis,
   output logic                  busy,
   output logic [CNT_W-1:0]      pkt_count,
   output logic                  underrun,
   output logic [1:0]            dbg_state
);

   localparam int BC_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;   // position of next loaded beat
   logic [TDATA_W-1:0]  tdata_q;
   logic                tvalid_q;
   logic                tlast_q;
   logic [CNT_W-1:0]    pkt_count_q;
   logic                underrun_q;

   logic issue_ok;
   logic out_free;
   logic load;
   logic beat_last;
   logic xfer;

   // Output register can accept a new word when empty or being drained now.
   assign out_free  = !tvalid_q || m_axis.tready;
   // DRAIN only keeps issuing until the open packet has all its beats loaded.
   assign issue_ok  = (state_q == RUN) || ((state_q == DRAIN) && (beat_cnt_q != '0));
   assign load      = issue_ok && !fifo_empty && out_free;
   assign beat_last = (beat_cnt_q == LAST_BEAT);
   assign xfer      = tvalid_q && m_axis.tready;

   assign beat_cnt_d = load ? (beat_last ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;

   // Next state. RUN looks at the beat count after this cycle's load so that
   // a beat 0 loaded in the same cycle enable drops still gets its packet
   // finished through DRAIN instead of being parked half-sent.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (enable) state_d = RUN;
         end
         RUN: begin
            if (!enable) state_d = (beat_cnt_d == '0) ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (enable)                 state_d = RUN;
            else if (beat_cnt_q == '0)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Output register: load has priority; otherwise retire an accepted beat.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else if (load) begin
         tdata_q  <= TDATA_W'(fifo_rd_data);
         tvalid_q <= 1'b1;
         tlast_q  <= beat_last;
      end else if (xfer) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end
   end

   // Status. A clear landing in the same cycle as an update wins.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         pkt_count_q <= '0;
         underrun_q  <= 1'b0;
      end else begin
         if (stat_clr)
            pkt_count_q <= '0;
         else if (xfer && tlast_q)
            pkt_count_q <= pkt_count_q + 1'b1;

         if (stat_clr)
            underrun_q <= 1'b0;
         else if (issue_ok && (beat_cnt_q != '0) && fifo_empty && out_free)
            underrun_q <= 1'b1;
      end
   end

   assign fifo_rd_en    = load;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign busy          = (state_q != IDLE) || tvalid_q;
   assign pkt_count     = pkt_count_q;
   assign underrun      = underrun_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_fifo_master.sv
module tb_axis_fifo_master;

   localparam int W = 17;   // {tlast, tdata[15:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;

   // ---------------- DUT 1 (PKT_LEN=16) ----------------
   logic        enable = 1'b0, stat_clr = 1'b0, fifo_empty = 1'b1;
   logic [13:0] fifo_rd_data = '0;
   logic        fifo_rd_en, busy, underrun;
   logic [15:0] pkt_count;
   logic [1:0]  dbg_state;
   axis_fifo_master_if #(.TDATA_W(16)) ax1 ();

   axis_fifo_master #(.DATA_W(14), .TDATA_W(16), .PKT_LEN(16), .CNT_W(16)) dut (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable), .stat_clr(stat_clr),
      .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .m_axis(ax1), .busy(busy), .pkt_count(pkt_count), .underrun(underrun),
      .dbg_state(dbg_state));

   // ---------------- DUT 2 (PKT_LEN=1) ----------------
   logic        enable_2 = 1'b0, stat_clr_2 = 1'b0, fifo_empty_2 = 1'b1;
   logic [13:0] fifo_rd_data_2 = '0;
   logic        fifo_rd_en_2, busy_2, underrun_2;
   logic [15:0] pkt_count_2;
   logic [1:0]  dbg_state_2;
   axis_fifo_master_if #(.TDATA_W(16)) ax2 ();

   axis_fifo_master #(.DATA_W(14), .TDATA_W(16), .PKT_LEN(1), .CNT_W(16)) dut2 (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .enable(enable_2), .stat_clr(stat_clr_2),
      .fifo_rd_data(fifo_rd_data_2), .fifo_empty(fifo_empty_2), .fifo_rd_en(fifo_rd_en_2),
      .m_axis(ax2), .busy(busy_2), .pkt_count(pkt_count_2), .underrun(underrun_2),
      .dbg_state(dbg_state_2));

   // ---------------- FIFO models and scoreboard ----------------
   logic [13:0]  fifo_q[$], pend_q[$], f2_q[$], p2_q[$];
   logic [W-1:0] exp_q[$], exp2_q[$];
   int   tx_pos = 0;
   int   n_tests = 0, n_fail = 0;
   int   hs_cnt = 0, rd_cnt = 0, v_cnt = 0, hs2_cnt = 0;
   int   cyc = 0;
   logic pop_pend = 1'b0, pop2_pend = 1'b0;
   logic [3:0] rdy_pat = 4'hF;
   logic en_v = 1'b0, en2_v = 1'b0;
   logic prev_stall = 1'b0, prev_last = 1'b0;
   logic [15:0] prev_data = '0;

   typedef struct {
      int         n_words;
      bit         rnd;
      logic [3:0] pat;
      int         exp_pkts;
      int         exp_vcyc;   // -1: not checked
   } vec_t;
   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected tlast comes from the bench's own packet position counter.
   function automatic void push_word(input logic [13:0] w);
      pend_q.push_back(w);
      exp_q.push_back({(tx_pos == 15), 2'b00, w});
      tx_pos = (tx_pos == 15) ? 0 : tx_pos + 1;
   endfunction

   function automatic void push_word2(input logic [13:0] w);
      p2_q.push_back(w);
      exp2_q.push_back({1'b1, 2'b00, w});
   endfunction

   function automatic void update_fifo();
      fifo_empty     = (fifo_q.size() == 0);
      fifo_rd_data   = fifo_empty ? 14'd0 : fifo_q[0];
      fifo_empty_2   = (f2_q.size() == 0);
      fifo_rd_data_2 = fifo_empty_2 ? 14'd0 : f2_q[0];
   endfunction

   task automatic clear_counts();
      hs_cnt = 0; rd_cnt = 0; v_cnt = 0; hs2_cnt = 0;
   endtask

   // Sampled at the falling edge; inputs only change 1 ns after a rising
   // edge, so what is seen here is what the next rising edge will act on.
   task automatic monitor();
      if (prev_stall)
         check("stall_hold", {14'd0, ax1.tvalid, ax1.tlast, ax1.tdata}, {14'd0, 1'b1, prev_last, prev_data});
      if (ax1.tvalid && !ax1.tready)
         check("no_pop_in_stall", {31'd0, fifo_rd_en}, 32'd0);
      prev_stall = ax1.tvalid && !ax1.tready;
      prev_data  = ax1.tdata;
      prev_last  = ax1.tlast;
      if (ax1.tvalid) v_cnt++;
      if (fifo_rd_en) begin rd_cnt++; pop_pend = 1'b1; end
      if (ax1.tvalid && ax1.tready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL beat: unexpected beat tdata=0x%0h tlast=%0b", ax1.tdata, ax1.tlast);
         end else begin
            check("beat", {15'd0, ax1.tlast, ax1.tdata}, {15'd0, exp_q.pop_front()});
         end
      end
      if (fifo_rd_en_2) pop2_pend = 1'b1;
      if (ax2.tvalid && ax2.tready) begin
         hs2_cnt++;
         if (exp2_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL beat2: unexpected beat tdata=0x%0h", ax2.tdata);
         end else begin
            check("beat2", {15'd0, ax2.tlast, ax2.tdata}, {15'd0, exp2_q.pop_front()});
         end
      end
   endtask

   task automatic cycle(input logic clr);
      @(posedge clk); #1;
      if (pop_pend && fifo_q.size() > 0) fifo_q.delete(0);
      if (pop2_pend && f2_q.size() > 0) f2_q.delete(0);
      pop_pend = 1'b0; pop2_pend = 1'b0;
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
      while (p2_q.size() > 0) f2_q.push_back(p2_q.pop_front());
      update_fifo();
      enable     = en_v;
      enable_2   = en2_v;
      stat_clr   = clr;
      stat_clr_2 = 1'b0;
      ax1.tready = rdy_pat[cyc % 4];
      ax2.tready = 1'b1;
      cyc++;
      @(negedge clk);
      monitor();
   endtask

   task automatic run_until_drained(input string name, input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle(1'b0);
         n++;
      end
      check(name, exp_q.size(), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] tmp[$];
      int n;
      int total;

      vecs[0] = '{n_words: 32, rnd: 1'b0, pat: 4'b1111, exp_pkts: 2, exp_vcyc: 32};
      vecs[1] = '{n_words: 32, rnd: 1'b0, pat: 4'b1001, exp_pkts: 2, exp_vcyc: -1};
      vecs[2] = '{n_words: 16, rnd: 1'b1, pat: 4'b0110, exp_pkts: 1, exp_vcyc: -1};
      vecs[3] = '{n_words: 48, rnd: 1'b1, pat: 4'b1111, exp_pkts: 3, exp_vcyc: 48};

      ax1.tready = 1'b0;
      ax2.tready = 1'b0;
      update_fifo();

      // Reset state
      #22;
      check("rst_tvalid",    {31'd0, ax1.tvalid}, 32'd0);
      check("rst_tdata",     {16'd0, ax1.tdata},  32'd0);
      check("rst_tlast",     {31'd0, ax1.tlast},  32'd0);
      check("rst_pkt_count", {16'd0, pkt_count},  32'd0);
      check("rst_underrun",  {31'd0, underrun},   32'd0);
      check("rst_busy",      {31'd0, busy},       32'd0);
      check("rst_state",     {30'd0, dbg_state},  32'd0);
      check("rst2_tvalid",   {31'd0, ax2.tvalid}, 32'd0);
      rst_n = 1'b1;
      en_v  = 1'b1;
      cycle(1'b0);
      cycle(1'b0);
      check("idle_to_run", {30'd0, dbg_state}, 32'd1);

      // Table-driven streaming rows
      for (int r = 0; r < 4; r++) begin
         rdy_pat = vecs[r].pat;
         cyc = 0;
         cycle(1'b1);
         clear_counts();
         for (int i = 0; i < vecs[r].n_words; i++)
            push_word(vecs[r].rnd ? 14'($urandom_range(0, 16383)) : 14'(i));
         run_until_drained("row_drain", 400);
         cycle(1'b0);
         cycle(1'b0);
         check("row_pkt_count", {16'd0, pkt_count}, vecs[r].exp_pkts);
         check("row_underrun",  {31'd0, underrun},  32'd0);
         check("row_beats",     hs_cnt, vecs[r].n_words);
         check("row_rd_en",     rd_cnt, vecs[r].n_words);
         if (vecs[r].exp_vcyc >= 0)
            check("row_full_rate", v_cnt, vecs[r].exp_vcyc);
      end

      // Enable dropped mid-packet: packet completes, then idle with data queued
      rdy_pat = 4'hF;
      cycle(1'b1);
      clear_counts();
      for (int i = 0; i < 32; i++) push_word(14'(i));
      n = 0;
      while (hs_cnt < 6 && n < 100) begin cycle(1'b0); n++; end
      check("stop_reach_beat5", {31'd0, (hs_cnt >= 6)}, 32'd1);
      en_v = 1'b0;
      for (int i = 0; i < 40; i++) cycle(1'b0);
      check("stop_beats",     hs_cnt, 32'd16);
      check("stop_rd_en",     rd_cnt, 32'd16);
      check("stop_fifo_left", fifo_q.size(), 32'd16);
      check("stop_pkt_count", {16'd0, pkt_count}, 32'd1);
      check("stop_state",     {30'd0, dbg_state}, 32'd0);
      check("stop_busy",      {31'd0, busy}, 32'd0);
      fifo_q.delete();
      exp_q.delete();
      tx_pos = 0;
      update_fifo();

      // Underrun mid-packet, clear-wins, then resume
      en_v = 1'b1;
      cycle(1'b1);
      clear_counts();
      for (int i = 0; i < 4; i++) push_word(14'(16'h100 + i));
      for (int i = 0; i < 20; i++) cycle(1'b0);
      check("ur_beats",     hs_cnt, 32'd4);
      check("ur_underrun",  {31'd0, underrun}, 32'd1);
      check("ur_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("ur_state",     {30'd0, dbg_state}, 32'd1);
      cycle(1'b1);
      cycle(1'b0);
      check("ur_clear_wins", {31'd0, underrun}, 32'd0);
      cycle(1'b0);
      check("ur_sets_again", {31'd0, underrun}, 32'd1);
      for (int i = 4; i < 16; i++) push_word(14'(16'h100 + i));
      run_until_drained("ur_drain", 100);
      cycle(1'b0);
      check("ur_resume_pkt", {16'd0, pkt_count}, 32'd1);
      check("ur_resume_beats", hs_cnt, 32'd16);
      check("ur_sticky", {31'd0, underrun}, 32'd1);
      cycle(1'b1);
      cycle(1'b0);
      check("clr_underrun",  {31'd0, underrun}, 32'd0);
      check("clr_pkt_count", {16'd0, pkt_count}, 32'd0);

      // Async reset mid-packet
      clear_counts();
      for (int i = 0; i < 32; i++) push_word(14'(16'h200 + i));
      n = 0;
      while (hs_cnt < 20 && n < 100) begin cycle(1'b0); n++; end
      check("pre_rst_pkt_count", {16'd0, pkt_count}, 32'd1);
      check("pre_rst_tvalid",    {31'd0, ax1.tvalid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_tvalid",    {31'd0, ax1.tvalid}, 32'd0);
      check("arst_tlast",     {31'd0, ax1.tlast},  32'd0);
      check("arst_pkt_count", {16'd0, pkt_count},  32'd0);
      check("arst_busy",      {31'd0, busy},       32'd0);
      pop_pend = 1'b0;
      pop2_pend = 1'b0;
      prev_stall = 1'b0;
      cycle(1'b0);
      cycle(1'b0);
      tmp = fifo_q;
      fifo_q.delete();
      exp_q.delete();
      tx_pos = 0;
      foreach (tmp[i]) push_word(tmp[i]);
      while ((tmp.size() + pend_q.size() - tmp.size()) % 16 != 0) push_word(14'($urandom_range(0, 16383)));
      total = pend_q.size();
      update_fifo();
      rst_n = 1'b1;
      clear_counts();
      run_until_drained("post_rst_drain", 200);
      cycle(1'b0);
      check("post_rst_beats",     hs_cnt, total);
      check("post_rst_pkt_count", {16'd0, pkt_count}, total / 16);
      check("post_rst_underrun",  {31'd0, underrun}, 32'd0);

      // PKT_LEN=1: every beat is a packet
      en2_v = 1'b1;
      for (int i = 0; i < 3; i++) push_word2(14'(16'h300 + i));
      for (int i = 0; i < 12; i++) cycle(1'b0);
      check("p1_beats",     hs2_cnt, 32'd3);
      check("p1_pkt_count", {16'd0, pkt_count_2}, 32'd3);
      check("p1_left",      exp2_q.size(), 32'd0);
      check("p1_underrun",  {31'd0, underrun_2}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
